// File: rtl/final_fulladder.sv
// 4-bit registered adder/subtractor built from a ripple chain of full-adder cells.
// sel=0 computes a+b+cin; sel=1 computes a-b-cin with cout=1 meaning no borrow.

module final_fulladder_cell (
  input  logic i_x,
  input  logic i_y,
  input  logic i_c,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_x ^ i_y ^ i_c;
  assign o_carry = (i_x & i_y) | (i_x & i_c) | (i_y & i_c);

endmodule

module final_fulladder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sel,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] w_y;
  logic [4:0] w_c;
  logic [3:0] w_sum;
  logic [3:0] r_s;
  logic       r_cout;

  // Subtract as a + ~b + ~cin, so an inverted borrow-in seeds the chain.
  assign w_y    = b ^ {4{sel}};
  assign w_c[0] = cin ^ sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cell
    final_fulladder_cell u_cell (
      .i_x     (a[gi]),
      .i_y     (w_y[gi]),
      .i_c     (w_c[gi]),
      .o_sum   (w_sum[gi]),
      .o_carry (w_c[gi+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= 4'h0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_sum;
      r_cout <= w_c[4];
    end
  end

  assign s    = r_s;
  assign cout = r_cout;

endmodule

// File: tb/tb_final_fulladder.sv
// Directed and exhaustive checks of final_fulladder against hand-computed values
// and an arithmetic reference model.

module tb_final_fulladder;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       sel;
  logic [3:0] s;
  logic       cout;

  int unsigned n_checks;
  int unsigned n_errors;

  final_fulladder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sel   (sel),
    .s     (s),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got {cout,s}=%b_%h expected %b_%h", tag, got[4], got[3:0], exp[4],
               exp[3:0]);
    end
  endtask

  // Drive on the falling edge, then sample just after the next rising edge.
  task automatic apply(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                       input logic ts);
    @(negedge clk);
    a   = ta;
    b   = tb;
    cin = tc;
    sel = ts;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] ref_model(input int ma, input int mb, input int mc,
                                           input int ms);
    int t;
    if (ms == 0) t = ma + mb + mc;
    else         t = ma + (15 - mb) + (1 - mc);
    return t[4:0];
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    a     = 4'($urandom_range(15));
    b     = 4'($urandom_range(15));
    cin   = 1'($urandom_range(1));
    sel   = 1'($urandom_range(1));
    #2;
    check_eq("reset_no_edge", {cout, s}, 5'b0_0000);
    @(posedge clk);
    #1;
    check_eq("reset_held", {cout, s}, 5'b0_0000);
    @(negedge clk);
    rst_n = 1'b1;

    apply(4'h2, 4'h1, 1'b1, 1'b0);
    check_eq("add_2_1_1", {cout, s}, 5'b0_0100);
    apply(4'h3, 4'h6, 1'b0, 1'b1);
    check_eq("sub_3_6_0", {cout, s}, 5'b0_1101);
    apply(4'hF, 4'h1, 1'b0, 1'b0);
    check_eq("add_wrap", {cout, s}, 5'b1_0000);
    apply(4'h5, 4'h5, 1'b0, 1'b1);
    check_eq("sub_5_5_0", {cout, s}, 5'b1_0000);
    apply(4'h5, 4'h5, 1'b1, 1'b1);
    check_eq("sub_5_5_1", {cout, s}, 5'b0_1111);
    apply(4'hF, 4'hF, 1'b1, 1'b0);
    check_eq("add_max", {cout, s}, 5'b1_1111);
    apply(4'h0, 4'hF, 1'b1, 1'b1);
    check_eq("sub_min", {cout, s}, 5'b0_0000);

    // Inputs changing between edges must not disturb the registered result.
    @(negedge clk);
    a = 4'h9; b = 4'h3; cin = 1'b0; sel = 1'b0;
    #1;
    check_eq("hold_between_edges", {cout, s}, 5'b0_0000);
    @(posedge clk);
    #1;
    check_eq("load_after_change", {cout, s}, 5'b0_1100);

    apply(4'h7, 4'h7, 1'b0, 1'b0);
    check_eq("midop_pre", {cout, s}, 5'b0_1110);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midop_reset_async", {cout, s}, 5'b0_0000);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("midop_released", {cout, s}, 5'b0_0000);
    @(posedge clk);
    #1;
    check_eq("midop_reload", {cout, s}, 5'b0_1110);

    for (int ms = 0; ms < 2; ms++) begin
      for (int ma = 0; ma < 16; ma++) begin
        for (int mb = 0; mb < 16; mb++) begin
          for (int mc = 0; mc < 2; mc++) begin
            apply(4'(ma), 4'(mb), 1'(mc), 1'(ms));
            check_eq($sformatf("exh_a%0d_b%0d_c%0d_s%0d", ma, mb, mc, ms), {cout, s},
                     ref_model(ma, mb, mc, ms));
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
